de10boy: RTL and testbench

DE10BOY -- requirements
Module: de10boy

---
 rtl/de10boy_pkg.sv | 44 ++++
 rtl/gb_ppu_timing.sv | 97 +++++++++
 rtl/de10boy.sv | 105 ++++++++++
 tb/tb_de10boy.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/de10boy_pkg.sv
// Shared constants, PPU mode encoding and shade palette for the de10boy video slice.
// The optional auto-scroll feature is enabled with the DE10BOY_SCROLL_EN macro.
package de10boy_pkg;

    // Game Boy PPU timing, in dots
    localparam int unsigned DOTS_PER_LINE = 456;
    localparam int unsigned LINES         = 154;
    localparam int unsigned OAM_DOTS      = 80;
    localparam int unsigned XFER_DOTS     = 172;
    localparam int unsigned VBLANK_LINE   = 144;
    localparam int unsigned FRAME_DOTS    = DOTS_PER_LINE * LINES;
    localparam int unsigned DOT_DIV       = 12;

    // 640x480 VGA timing, in pixels / lines
    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_VISIBLE    = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;
    localparam int unsigned V_TOTAL      = 525;

    // 160x144 game screen shown 2x scaled
    localparam int unsigned WIN_X0 = 160;
    localparam int unsigned WIN_Y0 = 96;
    localparam int unsigned WIN_W  = 320;
    localparam int unsigned WIN_H  = 288;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } ppu_mode_t;

    // Shade 0 is lightest; entry n sits at bits [4n+3:4n]
    localparam logic [15:0] SHADE_COLOR = {4'h0, 4'h5, 4'hA, 4'hF};

    function automatic logic [3:0] shade_to_color(input logic [1:0] shade);
        return SHADE_COLOR[{shade, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/gb_ppu_timing.sv
// Game Boy PPU dot/line/frame counters, mode decode and background coordinate decode.
// Scroll register auto-increment exists only when DE10BOY_SCROLL_EN is defined.
module gb_ppu_timing
    import de10boy_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       scroll_n,
    output logic [9:0] scrollX,
    output logic [9:0] scrollY
);

    logic [16:0] cycles;
    logic [8:0]  line_cycles;
    logic [7:0]  LY;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [5:0]  bgTileX;
    logic [5:0]  bgTileY;
    logic [4:0]  tileX;
    logic [4:0]  tileY;
    ppu_mode_t   ppu_mode;
    logic [5:0]  render_state;

    logic       line_wrap;
    logic       frame_wrap;
    logic [8:0] xfer_dot;

    assign line_wrap  = (line_cycles == 9'(DOTS_PER_LINE - 1));
    assign frame_wrap = (cycles == 17'(FRAME_DOTS - 1));

    always_ff @(posedge Clk) begin
        if (reset) begin
            line_cycles <= '0;
            LY          <= '0;
            cycles      <= '0;
        end else if (dot_en) begin
            line_cycles <= line_wrap ? 9'd0 : line_cycles + 9'd1;
            if (line_wrap) begin
                LY <= (LY == 8'(LINES - 1)) ? 8'd0 : LY + 8'd1;
            end
            cycles <= frame_wrap ? 17'd0 : cycles + 17'd1;
        end
    end

    always_comb begin
        xfer_dot = line_cycles - 9'(OAM_DOTS);

        if (LY >= 8'(VBLANK_LINE)) begin
            ppu_mode = VBLANK;
        end else if (line_cycles < 9'(OAM_DOTS)) begin
            ppu_mode = OAM;
        end else if (line_cycles < 9'(OAM_DOTS + XFER_DOTS)) begin
            ppu_mode = XFER;
        end else begin
            ppu_mode = HBLANK;
        end

        y            = {2'b00, LY + scrollY[7:0]};
        x            = '0;
        render_state = '0;
        // Horizontal position only advances while pixels are being pushed out
        if (ppu_mode == XFER) begin
            x            = {2'b00, xfer_dot[7:0] + scrollX[7:0]};
            render_state = {3'b000, xfer_dot[2:0]};
        end

        bgTileX = {1'b0, x[7:3]};
        bgTileY = {1'b0, y[7:3]};
        tileX   = {2'b00, x[2:0]};
        tileY   = {2'b00, y[2:0]};
    end

    // Fetch-side decode has no consumer in this slice yet
    logic unused_ppu_decode;
    assign unused_ppu_decode = ^{xfer_dot[8], x[9:8], y[9:8], bgTileX, bgTileY,
                                 tileX, tileY, render_state};

`ifdef DE10BOY_SCROLL_EN
    always_ff @(posedge Clk) begin
        if (reset) begin
            scrollX <= '0;
        end else if (dot_en && frame_wrap && !scroll_n) begin
            scrollX <= {2'b00, scrollX[7:0] + 8'd1};
        end
    end
    assign scrollY = '0;
`else
    assign scrollX = '0;
    assign scrollY = '0;

    logic unused_scroll;
    assign unused_scroll = ^{frame_wrap, scroll_n};
`endif

endmodule

// File: rtl/de10boy.sv
// DE10 top: clock-enable dividers, 640x480 VGA timing and a tile-checkerboard colour path
// driven by the PPU timing block. Build with DE10BOY_SCROLL_EN for KEY[1] auto-scroll.
module de10boy
    import de10boy_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    logic       rst;
    logic [3:0] dot_div;
    logic       dot_en;
    logic       pix_div;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] scrollX;
    logic [9:0] scrollY;

    assign rst    = reset | ~KEY[0];
    assign dot_en = (dot_div == 4'(DOT_DIV - 1));
    assign pix_en = pix_div;

    gb_ppu_timing ppu (
        .Clk      (Clk),
        .reset    (rst),
        .dot_en   (dot_en),
        .scroll_n (KEY[1]),
        .scrollX  (scrollX),
        .scrollY  (scrollY)
    );

    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync;
    logic       v_sync;
    logic       in_vis;
    logic       in_win;
    logic [9:0] hx;
    logic [9:0] vy;
    logic [7:0] src_x;
    logic [7:0] src_y;
    logic [1:0] shade;
    logic [3:0] pix_color;

    always_comb begin
        h_wrap = (hcount == 10'(H_TOTAL - 1));
        v_wrap = (vcount == 10'(V_TOTAL - 1));
        h_sync = (hcount >= 10'(H_SYNC_START)) && (hcount < 10'(H_SYNC_END));
        v_sync = (vcount >= 10'(V_SYNC_START)) && (vcount < 10'(V_SYNC_END));
        in_vis = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
        in_win = (hcount >= 10'(WIN_X0)) && (hcount < 10'(WIN_X0 + WIN_W)) &&
                 (vcount >= 10'(WIN_Y0)) && (vcount < 10'(WIN_Y0 + WIN_H));

        // 2x scaling: drop the low bit of the window-relative position
        hx    = hcount - 10'(WIN_X0);
        vy    = vcount - 10'(WIN_Y0);
        src_x = hx[8:1] + scrollX[7:0];
        src_y = vy[8:1] + scrollY[7:0];
        shade = src_x[4:3] + src_y[4:3];

        pix_color = (in_vis && in_win) ? shade_to_color(shade) : 4'h0;
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            dot_div <= '0;
            pix_div <= 1'b0;
            hcount  <= '0;
            vcount  <= '0;
            VGA_HS  <= 1'b1;
            VGA_VS  <= 1'b1;
            VGA_R   <= '0;
            VGA_G   <= '0;
            VGA_B   <= '0;
        end else begin
            dot_div <= dot_en ? 4'd0 : dot_div + 4'd1;
            pix_div <= ~pix_div;
            if (pix_en) begin
                if (h_wrap) begin
                    hcount <= '0;
                    vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
                VGA_HS <= ~h_sync;
                VGA_VS <= ~v_sync;
                VGA_R  <= pix_color;
                VGA_G  <= pix_color;
                VGA_B  <= pix_color;
            end
        end
    end

    logic unused_top;
    assign unused_top = ^{hx[9], hx[0], vy[9], vy[0], src_x[7:5], src_x[2:0],
                          src_y[7:5], src_y[2:0], scrollX[9:8], scrollY[9:8]};

endmodule

// File: tb/tb_de10boy.sv
// Directed bench for de10boy: PPU counters and modes, VGA sync/colour, resets and scroll.
// Long waits are skipped by jumping the counters to just before the event of interest.
module tb_de10boy;

    logic       Clk = 1'b0;
    logic       reset;
    logic [1:0] KEY;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;

    int total = 0;
    int bad   = 0;

`ifdef DE10BOY_SCROLL_EN
    localparam int SCROLL_FRAMES = 3;
`else
    localparam int SCROLL_FRAMES = 0;
`endif

    logic [7:0]  f_ly;
    logic [8:0]  f_lc;
    logic [16:0] f_cyc;
    logic [9:0]  f_h;
    logic [9:0]  f_v;

    de10boy dut (
        .Clk    (Clk),
        .reset  (reset),
        .KEY    (KEY),
        .VGA_HS (VGA_HS),
        .VGA_VS (VGA_VS),
        .VGA_R  (VGA_R),
        .VGA_G  (VGA_G),
        .VGA_B  (VGA_B)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; any 12 consecutive edges hold exactly one dot
    task automatic run_dots(input int n);
        repeat (n * 12) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic ppu_jump(input int ly, input int lc);
        f_ly  = 8'(ly);
        f_lc  = 9'(lc);
        f_cyc = 17'(ly * 456 + lc);
        force dut.ppu.LY          = f_ly;
        force dut.ppu.line_cycles = f_lc;
        force dut.ppu.cycles      = f_cyc;
        #1;
        release dut.ppu.LY;
        release dut.ppu.line_cycles;
        release dut.ppu.cycles;
    endtask

    task automatic vga_jump(input int h, input int v);
        f_h = 10'(h);
        f_v = 10'(v);
        force dut.hcount = f_h;
        force dut.vcount = f_v;
        #1;
        release dut.hcount;
        release dut.vcount;
    endtask

    task automatic wait_pix(input int h, input int v);
        bit seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge Clk);
            if (dut.hcount == 10'(h) && dut.vcount == 10'(v)) seen = 1'b1;
        end
        check($sformatf("reach_%0d_%0d", h, v), 32'(seen), 32'd1);
    endtask

    task automatic check_rgb(input string tag, input logic [3:0] exp);
        check(tag, {VGA_R, VGA_G, VGA_B}, {exp, exp, exp});
    endtask

    task automatic check_ppu(input string tag, input int lc, input int ly, input int cyc,
                             input int mode);
        check({tag, "_lc"}, 32'(dut.ppu.line_cycles), lc);
        check({tag, "_ly"}, 32'(dut.ppu.LY), ly);
        check({tag, "_cyc"}, 32'(dut.ppu.cycles), cyc);
        check({tag, "_mode"}, 32'(dut.ppu.ppu_mode), mode);
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 2'b11;
        repeat (7) @(posedge Clk);
        @(negedge Clk);
        check_ppu("rst", 0, 0, 0, 2);
        check("rst_hs", 32'(VGA_HS), 1);
        check("rst_vs", 32'(VGA_VS), 1);
        check_rgb("rst_rgb", 4'h0);
        reset = 1'b0;

        // One full line of dots
        run_dots(456);
        check_ppu("line1", 0, 1, 456, 2);

        // KEY[0] acts as reset
        KEY[0] = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check_ppu("key0", 0, 0, 0, 2);
        KEY[0] = 1'b1;

        // Mode boundaries along line 0
        run_dots(79);
        check("lc79_mode", 32'(dut.ppu.ppu_mode), 2);
        run_dots(1);
        check("lc80_mode", 32'(dut.ppu.ppu_mode), 3);
        check("lc80_x", 32'(dut.ppu.x), 0);
        check("lc80_rs", 32'(dut.ppu.render_state), 0);
        run_dots(1);
        check("lc81_x", 32'(dut.ppu.x), 1);
        check("lc81_rs", 32'(dut.ppu.render_state), 1);
        run_dots(170);
        check("lc251_mode", 32'(dut.ppu.ppu_mode), 3);
        check("lc251_x", 32'(dut.ppu.x), 171);
        check("lc251_rs", 32'(dut.ppu.render_state), 3);
        run_dots(1);
        check("lc252_mode", 32'(dut.ppu.ppu_mode), 0);
        check("lc252_x", 32'(dut.ppu.x), 0);
        check("lc252_rs", 32'(dut.ppu.render_state), 0);
        check("lc252_y", 32'(dut.ppu.y), 0);
        run_dots(204);
        check_ppu("line1b", 0, 1, 456, 2);

        // Reset mid-line at line_cycles 200
        run_dots(200);
        check("mid_pre_lc", 32'(dut.ppu.line_cycles), 200);
        reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_ppu("mid_rst", 0, 0, 0, 2);
        check("mid_rst_hs", 32'(VGA_HS), 1);
        check("mid_rst_vs", 32'(VGA_VS), 1);
        check_rgb("mid_rst_rgb", 4'h0);
        reset = 1'b0;
        run_dots(1);
        check("resume_lc", 32'(dut.ppu.line_cycles), 1);

        // VBlank entry and frame wrap
        ppu_jump(143, 455);
        check("l143_mode", 32'(dut.ppu.ppu_mode), 0);
        run_dots(1);
        check_ppu("vblank", 0, 144, 65664, 1);
        check("vblank_y", 32'(dut.ppu.y), 144);
        ppu_jump(153, 455);
        check("l153_mode", 32'(dut.ppu.ppu_mode), 1);
        run_dots(1);
        check_ppu("frame_wrap", 0, 0, 0, 2);
        check("noscroll_sx", 32'(dut.ppu.scrollX), 0);

        // Horizontal sync edges (outputs lag the counter by one pixel)
        vga_jump(650, 10);
        wait_pix(656, 10);
        check("hs_655", 32'(VGA_HS), 1);
        wait_pix(657, 10);
        check("hs_656", 32'(VGA_HS), 0);
        wait_pix(752, 10);
        check("hs_751", 32'(VGA_HS), 0);
        wait_pix(753, 10);
        check("hs_752", 32'(VGA_HS), 1);

        // Vertical sync edges
        vga_jump(790, 489);
        wait_pix(0, 490);
        check("vs_489", 32'(VGA_VS), 1);
        wait_pix(1, 490);
        check("vs_490", 32'(VGA_VS), 0);
        vga_jump(795, 491);
        wait_pix(0, 492);
        check("vs_491", 32'(VGA_VS), 0);
        wait_pix(1, 492);
        check("vs_492", 32'(VGA_VS), 1);

        // Colour along the first game row
        vga_jump(150, 96);
        wait_pix(160, 96);
        check_rgb("rgb_h159", 4'h0);
        wait_pix(161, 96);
        check_rgb("rgb_h160", 4'hF);
        wait_pix(163, 96);
        check_rgb("rgb_h162", 4'hF);
        wait_pix(177, 96);
        check_rgb("rgb_h176", 4'hA);
        wait_pix(193, 96);
        check_rgb("rgb_h192", 4'h5);
        wait_pix(225, 96);
        check_rgb("rgb_h224", 4'hF);

        // Reset while the picture is lit and the PPU sits at line_cycles 200
        ppu_jump(5, 200);
        check("win_pre_lc", 32'(dut.ppu.line_cycles), 200);
        reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("win_rst_lc", 32'(dut.ppu.line_cycles), 0);
        check("win_rst_cyc", 32'(dut.ppu.cycles), 0);
        check("win_rst_h", 32'(dut.hcount), 0);
        check("win_rst_hs", 32'(VGA_HS), 1);
        check("win_rst_vs", 32'(VGA_VS), 1);
        check_rgb("win_rst_rgb", 4'h0);
        reset = 1'b0;

        // Window edges
        vga_jump(150, 112);
        wait_pix(177, 112);
        check_rgb("rgb_v112_h176", 4'h5);
        wait_pix(480, 112);
        check_rgb("rgb_h479", 4'hF);
        wait_pix(481, 112);
        check_rgb("rgb_h480", 4'h0);
        vga_jump(150, 383);
        wait_pix(161, 383);
        check_rgb("rgb_v383", 4'hA);
        vga_jump(150, 384);
        wait_pix(161, 384);
        check_rgb("rgb_v384", 4'h0);

        // Scroll button held across three frame wraps
        KEY[1] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            ppu_jump(153, 455);
            run_dots(1);
        end
        KEY[1] = 1'b1;
        check("scroll_sx", 32'(dut.ppu.scrollX), SCROLL_FRAMES);
        check("scroll_lc", 32'(dut.ppu.line_cycles), 0);
        run_dots(80);
        check("scroll_x0", 32'(dut.ppu.x), SCROLL_FRAMES);
        vga_jump(150, 96);
        wait_pix(163, 96);
        check_rgb("scroll_rgb_h162", 4'hF);
        wait_pix(171, 96);
        check_rgb("scroll_rgb_h170", (SCROLL_FRAMES == 3) ? 4'hA : 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
